heartbeat_seq: RTL and testbench



---
 rtl/heartbeat_seq.sv | 166 ++++++++++++++++
 tb/tb_heartbeat_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/heartbeat_seq.sv
// heartbeat_seq: outward bar-sweep animation for the multiplexed 7-seg display.
// Optional HEARTBEAT_BOUNCE_EN adds a RETURN sweep back toward the centre.
module heartbeat_seq #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1388889,
    parameter int GAP_TICKS  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic [2*NUM_DIGITS-1:0] digits_o,
    output logic                    beat_start,
    output logic                    busy
);
    localparam int H  = NUM_DIGITS / 2;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (2 * H > 1) ? $clog2(2 * H) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(2 * H - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

`ifdef HEARTBEAT_BOUNCE_EN
    typedef enum logic [1:0] {IDLE, SWEEP, GAP, RETURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SWEEP, GAP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [2*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    beat_q, beat_d;
    logic                    busy_q, busy_d;
    logic                    tick;
    logic                    beat_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
            digits_q <= '0;
            beat_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            digits_q <= digits_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        beat_d    = 1'b0;
        beat_done = 1'b0;
        tick      = (cnt_q == TICK_LAST);
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SWEEP;
                    phase_d = '0;
                    beat_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (phase_q != PH_LAST) begin
                        phase_d = phase_q + 1'b1;
                    end else begin
`ifdef HEARTBEAT_BOUNCE_EN
                        if (phase_q == '0) begin
                            beat_done = 1'b1;
                        end else begin
                            state_d = RETURN;
                            phase_d = phase_q - 1'b1;
                        end
`else
                        beat_done = 1'b1;
`endif
                    end
                end
            end
`ifdef HEARTBEAT_BOUNCE_EN
            RETURN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (phase_q == '0) begin
                        beat_done = 1'b1;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
            end
`endif
            GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = SWEEP;
                        phase_d = '0;
                        beat_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // End of the visible sweep: either blank gap or straight into a new beat.
        if (beat_done) begin
            if (GAP_TICKS == 0) begin
                state_d = SWEEP;
                phase_d = '0;
                beat_d  = 1'b1;
            end else begin
                state_d = GAP;
                gap_d   = '0;
            end
        end

        if (state_d == IDLE) begin
            phase_d = '0;
            gap_d   = '0;
        end

        if (state_q == IDLE || state_d == IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d   = (state_d != IDLE);
        digits_d = '0;
        if (state_d == SWEEP
`ifdef HEARTBEAT_BOUNCE_EN
            || state_d == RETURN
`endif
            ) begin
            for (int j = 0; j < H; j++) begin
                if ((phase_d >> 1) == PW'(j)) begin
                    digits_d[2*(H-1-j) +: 2] = phase_d[0] ? 2'b01 : 2'b10;
                    digits_d[2*(H+j) +: 2]   = phase_d[0] ? 2'b10 : 2'b01;
                end
            end
        end
    end

    assign digits_o   = digits_q;
    assign beat_start = beat_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_heartbeat_seq.sv
// tb_heartbeat_seq: directed vectors for heartbeat_seq in three configurations.
// Expected sequences switch with HEARTBEAT_BOUNCE_EN.
module tb_heartbeat_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  d0, d1;
    logic [11:0] d2;
    logic        bs0, bs1, bs2, by0, by1, by2;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    heartbeat_seq #(.NUM_DIGITS(4), .TICK_DIV(4), .GAP_TICKS(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .digits_o(d0), .beat_start(bs0), .busy(by0));
    heartbeat_seq #(.NUM_DIGITS(4), .TICK_DIV(4), .GAP_TICKS(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .digits_o(d1), .beat_start(bs1), .busy(by1));
    heartbeat_seq #(.NUM_DIGITS(6), .TICK_DIV(1), .GAP_TICKS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .digits_o(d2), .beat_start(bs2), .busy(by2));

    typedef struct {
        logic       en;
        int         n;
        logic [7:0] dig;
        logic       bs;
        logic       busy;
    } vec_t;

`ifdef HEARTBEAT_BOUNCE_EN
    localparam int L0 = 9;
    localparam int L1 = 7;
    localparam int L2 = 13;
    logic [11:0] s0 [L0] = '{12'h018, 12'h024, 12'h042, 12'h081, 12'h042,
                             12'h024, 12'h018, 12'h000, 12'h000};
    logic [11:0] s1 [L1] = '{12'h018, 12'h024, 12'h042, 12'h081, 12'h042,
                             12'h024, 12'h018};
    logic [11:0] s2 [L2] = '{12'h060, 12'h090, 12'h108, 12'h204, 12'h402,
                             12'h801, 12'h402, 12'h204, 12'h108, 12'h090,
                             12'h060, 12'h000, 12'h000};
`else
    localparam int L0 = 6;
    localparam int L1 = 4;
    localparam int L2 = 8;
    logic [11:0] s0 [L0] = '{12'h018, 12'h024, 12'h042, 12'h081, 12'h000,
                             12'h000};
    logic [11:0] s1 [L1] = '{12'h018, 12'h024, 12'h042, 12'h081};
    logic [11:0] s2 [L2] = '{12'h060, 12'h090, 12'h108, 12'h204, 12'h402,
                             12'h801, 12'h000, 12'h000};
`endif

    vec_t tbl[$];

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back('{1'b1, 4, 8'h18, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h24, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h42, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h81, 1'b0, 1'b1});
`ifdef HEARTBEAT_BOUNCE_EN
        tbl.push_back('{1'b1, 4, 8'h42, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h24, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h18, 1'b0, 1'b1});
`endif
        tbl.push_back('{1'b1, 8, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h18, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4, 8'h24, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 2, 8'h42, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4, 8'h18, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 2, 8'h24, 1'b0, 1'b1});

        // Reset state, before any clock edge
        #2;
        chk("rst dig", 12'(d0), 12'h000);
        chk("rst bs", 12'(bs0), 12'h0);
        chk("rst busy", 12'(by0), 12'h0);
        #10;
        reset_n = 1'b1;
        step();
        chk("idle dig", 12'(d0), 12'h000);
        chk("idle busy", 12'(by0), 12'h0);

        foreach (tbl[i]) begin
            enable = tbl[i].en;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                chk($sformatf("tbl%0d.%0d dig", i, k), 12'(d0), 12'(tbl[i].dig));
                chk($sformatf("tbl%0d.%0d bs", i, k), 12'(bs0),
                    12'((k == 0) ? tbl[i].bs : 1'b0));
                chk($sformatf("tbl%0d.%0d busy", i, k), 12'(by0), 12'(tbl[i].busy));
            end
        end

        // Asynchronous reset mid-phase, no clock edge in between
        #2;
        reset_n = 1'b0;
        #1;
        chk("async dig", 12'(d0), 12'h000);
        chk("async busy", 12'(by0), 12'h0);
        chk("async bs", 12'(bs0), 12'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("inrst%0d dig", k), 12'(d0), 12'h000);
            chk($sformatf("inrst%0d busy", k), 12'(by0), 12'h0);
        end
        enable = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("postrst%0d busy", k), 12'(by0), 12'h0);
            chk($sformatf("postrst%0d dig", k), 12'(d0), 12'h000);
        end
        enable = 1'b1;
        step();
        chk("reen dig", 12'(d0), 12'h018);
        chk("reen bs", 12'(bs0), 12'h1);

        // All three configurations from a common start
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #2;
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int c = 0; c < 72; c++) begin
            step();
            chk($sformatf("g2 c%0d dig", c), 12'(d0), s0[(c / 4) % L0]);
            chk($sformatf("g2 c%0d bs", c), 12'(bs0), 12'((c % (4 * L0)) == 0));
            chk($sformatf("g0 c%0d dig", c), 12'(d1), s1[(c / 4) % L1]);
            chk($sformatf("g0 c%0d bs", c), 12'(bs1), 12'((c % (4 * L1)) == 0));
            chk($sformatf("n6 c%0d dig", c), d2, s2[c % L2]);
            chk($sformatf("n6 c%0d bs", c), 12'(bs2), 12'((c % L2) == 0));
            chk($sformatf("n6 c%0d busy", c), 12'(by2), 12'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
